// File: rtl/ram_dp_clr_pkg.sv
// ----------------------------------------------------------------------------
// ram_dp_clr_pkg
//   Shared types and default sizes for the dual-port clearable RAM.
//   BUS_WIDTH  : default address width (DEPTH = 2**BUS_WIDTH words)
//   DATA_WIDTH : default word width
//   collide_e  : result returned by a same-address read/write in one cycle
//   ramst_e    : clear sequencer state
// ----------------------------------------------------------------------------
package ram_dp_clr_pkg;

  localparam int BUS_WIDTH  = 8;
  localparam int DATA_WIDTH = 8;

  typedef enum logic {
    RD_FIRST = 1'b0,  // read returns the word as it was before the write
    WR_FIRST = 1'b1   // read returns the word being written
  } collide_e;

  typedef enum logic {
    CLEAR = 1'b0,     // sweeping zeros through the array, user port locked out
    READY = 1'b1      // normal read/write service
  } ramst_e;

endpackage : ram_dp_clr_pkg

// File: rtl/ram_clear_seq.sv
// ----------------------------------------------------------------------------
// ram_clear_seq
//   Clear sequencer for ram_dp_clr. Walks a counter over every address after
//   reset or on clr_req, requesting a zero write at each, then hands the
//   array back to the user port.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset; restarts the sweep at 0
//   clr_req  in   start a new sweep; only honoured in READY
//   busy     out  registered, high while the sweep is in progress
//   clr_we   out  write strobe for the sweep
//   clr_addr out  address being zeroed this cycle
// ----------------------------------------------------------------------------
module ram_clear_seq
  import ram_dp_clr_pkg::*;
#(
  parameter int ADDR_W = BUS_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  // One spare bit so the final address (all ones) is compared against a
  // value that cannot be confused with a wrap back to zero.
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  ramst_e          state;
  logic [ADDR_W:0] cnt;

  // NOTE: every register here is state, so all assignments are non-blocking;
  // blocking assignments would make the result depend on evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt[ADDR_W-1:0];

endmodule : ram_clear_seq

// File: rtl/ram_dp_clr.sv
// ----------------------------------------------------------------------------
// ram_dp_clr
//   Simple dual-port block RAM with a hardware clear sweep and registered
//   debug taps mirroring the lowest N_TAPS words.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset; starts a clear sweep
//   clr_req  in   request a full-array clear (READY only)
//   busy     out  high while clearing; rd/wr requests are dropped
//   rd_en    in   read request
//   addr_rd  in   read address
//   data_rd  out  registered read data (holds when no read is accepted)
//   rd_valid out  data_rd was loaded by the read accepted on the last edge
//   wr_en    in   write request
//   addr_wr  in   write address
//   data_wr  in   write data
//   taps     out  word k at [k*DATA_W +: DATA_W] mirrors memory[k]
// ----------------------------------------------------------------------------
module ram_dp_clr
  import ram_dp_clr_pkg::*;
#(
  parameter int       ADDR_W  = BUS_WIDTH,
  parameter int       DATA_W  = DATA_WIDTH,
  parameter int       N_TAPS  = 2,
  parameter collide_e COLLIDE = RD_FIRST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        addr_rd,
  output logic [DATA_W-1:0]        data_rd,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        addr_wr,
  input  logic [DATA_W-1:0]        data_wr,
  output logic [N_TAPS*DATA_W-1:0] taps
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  // Write port after the clear/user mux.
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic re;
  logic collide;

  logic [DATA_W-1:0] mem   [DEPTH];
  logic [DATA_W-1:0] tap_q [N_TAPS];

  ram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // The sweep owns the write port while clearing; requests seen on a reset
  // edge are dropped so the sweep always restarts from a clean state.
  // NOTE: each output gets a default before any branch, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    we    = 1'b0;
    waddr = addr_wr;
    wdata = data_wr;
    if (!rst) begin
      if (clr_we) begin
        we    = 1'b1;
        waddr = clr_addr;
        wdata = '0;
      end else begin
        we = wr_en;
      end
    end
  end

  assign re      = rd_en && !busy && !rst;
  assign collide = re && wr_en && (addr_rd == addr_wr);

  // NOTE: the array has no reset; the clear sweep zeroes it instead, which
  // keeps it a plain write-port memory that maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register. The array read sees the pre-write contents, which is the
  // RD_FIRST behaviour; WR_FIRST bypasses the incoming write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_rd  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= re;
      if (re) begin
        if (COLLIDE == WR_FIRST && collide) begin
          data_rd <= data_wr;
        end else begin
          data_rd <= mem[addr_rd];
        end
      end
    end
  end

  // Shadow copies of the low words, loaded from the muxed write port so that
  // clear-sweep writes zero them as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        tap_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_TAPS; k++) begin
        if (we && waddr == ADDR_W'(k)) begin
          tap_q[k] <= wdata;
        end
      end
    end
  end

  for (genvar g = 0; g < N_TAPS; g++) begin : g_taps
    assign taps[g*DATA_W +: DATA_W] = tap_q[g];
  end

endmodule : ram_dp_clr

// File: tb/tb_ram_dp_clr.sv
// ----------------------------------------------------------------------------
// tb_ram_dp_clr
//   Drives an RD_FIRST and a WR_FIRST instance of ram_dp_clr (ADDR_W=4,
//   DATA_W=8, N_TAPS=2) with identical stimulus. A reference memory model
//   predicts read data, which is queued when a read is issued and popped when
//   each instance raises rd_valid. busy, rd_valid, held data_rd and taps are
//   compared after every edge.
// ----------------------------------------------------------------------------
module tb_ram_dp_clr;
  import ram_dp_clr_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int NT    = 2;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_req;
  logic          rd_en;
  logic [AW-1:0] addr_rd;
  logic          wr_en;
  logic [AW-1:0] addr_wr;
  logic [DW-1:0] data_wr;

  logic             busy_rf, busy_wf;
  logic [DW-1:0]    data_rd_rf, data_rd_wf;
  logic             rd_valid_rf, rd_valid_wf;
  logic [NT*DW-1:0] taps_rf, taps_wf;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [DW-1:0]    mdl [DEPTH];
  logic [NT*DW-1:0] mtaps;
  bit               mbusy;
  int               mcnt;
  logic [DW-1:0]    held_rf, held_wf;
  logic [DW-1:0]    q_rf [$];
  logic [DW-1:0]    q_wf [$];

  always #5 clk = ~clk;

  ram_dp_clr #(.ADDR_W(AW), .DATA_W(DW), .N_TAPS(NT), .COLLIDE(RD_FIRST)) u_rf (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_rf),
    .rd_en(rd_en), .addr_rd(addr_rd), .data_rd(data_rd_rf), .rd_valid(rd_valid_rf),
    .wr_en(wr_en), .addr_wr(addr_wr), .data_wr(data_wr), .taps(taps_rf)
  );

  ram_dp_clr #(.ADDR_W(AW), .DATA_W(DW), .N_TAPS(NT), .COLLIDE(WR_FIRST)) u_wf (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_wf),
    .rd_en(rd_en), .addr_rd(addr_rd), .data_rd(data_rd_wf), .rd_valid(rd_valid_wf),
    .wr_en(wr_en), .addr_wr(addr_wr), .data_wr(data_wr), .taps(taps_wf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, advance the model, wait for the edge and
  // compare both instances against the model.
  task automatic cycle(input logic r, input logic re, input logic [AW-1:0] ra,
                       input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic cr);
    bit rd_issued;
    rst = r; rd_en = re; addr_rd = ra; wr_en = we; addr_wr = wa; data_wr = wd; clr_req = cr;
    rd_issued = 1'b0;
    if (r) begin
      mbusy = 1'b1; mcnt = 0; mtaps = '0; held_rf = '0; held_wf = '0;
    end else if (mbusy) begin
      mdl[mcnt] = '0;
      if (mcnt < NT) mtaps[mcnt*DW +: DW] = '0;
      mcnt++;
      if (mcnt == DEPTH) mbusy = 1'b0;
    end else begin
      if (re) begin
        rd_issued = 1'b1;
        q_rf.push_back(mdl[ra]);
        q_wf.push_back((we && wa == ra) ? wd : mdl[ra]);
      end
      if (we) begin
        mdl[wa] = wd;
        if (int'(wa) < NT) mtaps[int'(wa)*DW +: DW] = wd;
      end
      if (cr) begin
        mbusy = 1'b1; mcnt = 0;
      end
    end

    @(posedge clk);
    #1;

    check("busy_rf", 32'(busy_rf), 32'(mbusy));
    check("busy_wf", 32'(busy_wf), 32'(mbusy));
    check("rd_valid_rf", 32'(rd_valid_rf), 32'(rd_issued));
    check("rd_valid_wf", 32'(rd_valid_wf), 32'(rd_issued));
    if (rd_valid_rf === 1'b1) begin
      if (q_rf.size() == 0) check("rf_unexpected_valid", 32'(1), 32'(0));
      else held_rf = q_rf.pop_front();
    end
    if (rd_valid_wf === 1'b1) begin
      if (q_wf.size() == 0) check("wf_unexpected_valid", 32'(1), 32'(0));
      else held_wf = q_wf.pop_front();
    end
    check("data_rd_rf", 32'(data_rd_rf), 32'(held_rf));
    check("data_rd_wf", 32'(data_rd_wf), 32'(held_wf));
    check("taps_rf", 32'(taps_rf), 32'(mtaps));
    check("taps_wf", 32'(taps_wf), 32'(mtaps));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cycle(1'b0, 1'b1, a, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cycle(1'b0, 1'b0, '0, 1'b1, a, d, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 'x;
    mtaps = '0; mbusy = 1'b1; mcnt = 0; held_rf = '0; held_wf = '0;

    // 1: reset for two cycles, then exactly DEPTH clearing edges
    cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    n = 0;
    do begin idle(); n++; end while (busy_rf === 1'b1 && n < 40);
    check("clr_len_after_rst", 32'(n), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle();

    // 2: write then read back, then hold
    wr(4'd3, 8'hA5);
    rd(4'd3);
    idle();
    check("hold_a5", 32'(data_rd_rf), 32'h0000_00A5);

    // 3: independent read and write in one cycle
    wr(4'd7, 8'h11);
    cycle(1'b0, 1'b1, 4'd7, 1'b1, 4'd5, 8'h3C, 1'b0);
    rd(4'd5);

    // 4: same-address collision
    wr(4'd9, 8'h22);
    cycle(1'b0, 1'b1, 4'd9, 1'b1, 4'd9, 8'h77, 1'b0);
    check("collide_rf", 32'(data_rd_rf), 32'h0000_0022);
    check("collide_wf", 32'(data_rd_wf), 32'h0000_0077);
    rd(4'd9);

    // 5: tap mirror, then clear request with writes attempted while busy
    wr(4'd1, 8'h5A);
    check("tap1", 32'(taps_rf[15:8]), 32'h0000_005A);
    wr(4'd0, 8'hC3);
    cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
    n = 0;
    do begin
      cycle(1'b0, 1'b1, AW'(n), 1'b1, AW'(n + 1), 8'hFF, 1'b0);
      n++;
    end while (busy_rf === 1'b1 && n < 40);
    check("clr_len_req", 32'(n), 32'(DEPTH));
    rd(4'd0); rd(4'd1); rd(4'd3); rd(4'd5); rd(4'd9);

    // 6: reset in the middle of a sweep restarts it; clr_req mid-sweep ignored
    wr(4'd2, 8'h44);
    wr(4'd12, 8'h99);
    cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++) idle();
    cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    n = 0;
    do begin
      cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, (n == 3) || (n == 14));
      n++;
    end while (busy_rf === 1'b1 && n < 40);
    check("clr_len_restart", 32'(n), 32'(DEPTH));
    rd(4'd2); rd(4'd12);

    // Mixed random traffic
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
            DW'($urandom_range(0, 255)), 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle();

    check("q_rf_drained", 32'(q_rf.size()), 32'(0));
    check("q_wf_drained", 32'(q_wf.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram_dp_clr
